bus_arbiter_qos: RTL and testbench

Parametrised successor to the coherence-bus arbiter. Grants the shared snoop bus to one of N cache controllers. Adds an urgent request class, a selectable fixed-priority mode, and a bounded hold time with forced preemption that a per-requester lock can suppress for atomic read-modify-write sequences. Sits between the N cache controllers and the bus mux/snoop broadcast logic.

---
 rtl/bus_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 36 +++
 rtl/bus_arbiter_qos.sv | 111 +++++++++++
 tb/tb_bus_arbiter_qos.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, width helper and assertion macro for the QoS bus arbiter

`ifndef BUS_ARB_ASSERT_ONEHOT0
`define BUS_ARB_ASSERT_ONEHOT0(clk_s, rst_s, sig) \
  assert property (@(posedge clk_s) disable iff (rst_s) $onehot0(sig))
`endif

package bus_arb_pkg;

  // Arbiter is either free (IDLE) or has a current bus owner (OWNED).
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Width of a binary requester index; a single requester still needs one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin / fixed-priority winner picker

module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic           fixed,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           found
);

  // Scan candidates in priority order: from index 0 in fixed mode, or
  // starting just after the previous winner (wrapping) in round-robin mode.
  always_comb begin
    int c;
    logic [IDW-1:0] ci;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    c      = 0;
    ci     = '0;
    for (int k = 0; k < N; k++) begin
      c  = fixed ? k : ((int'(last) + 1 + k) % N);
      ci = IDW'(c);
      if (!found && req[ci]) begin
        found      = 1'b1;
        idx        = ci;
        onehot[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_qos.sv
// rtl/bus_arbiter_qos.sv - snoop-bus arbiter with urgent class, bounded hold and lockable preemption

module bus_arbiter_qos
  import bus_arb_pkg::*;
#(
  parameter int N         = 2,
  parameter int MAX_HOLD  = 16,
  parameter int FIXED_PRI = 0,
  parameter int IDW       = idw(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   urgent,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           preempt
);

  // hold_cnt counts up to MAX_HOLD-1 and sticks there; unlimited hold keeps it at 0.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  state_t         state;
  logic [HW-1:0]  hold_cnt;
  logic [IDW-1:0] last;

  logic [N-1:0]   u_oh, a_oh, sel_oh;
  logic [IDW-1:0] u_idx, a_idx, sel_idx;
  logic           u_found, a_found;
  logic           others_wait;

  rr_pick #(.N(N), .IDW(IDW)) u_pick_urgent (
    .req    (req & urgent),
    .last   (last),
    .fixed  (FIXED_PRI != 0),
    .onehot (u_oh),
    .idx    (u_idx),
    .found  (u_found)
  );

  rr_pick #(.N(N), .IDW(IDW)) u_pick_all (
    .req    (req),
    .last   (last),
    .fixed  (FIXED_PRI != 0),
    .onehot (a_oh),
    .idx    (a_idx),
    .found  (a_found)
  );

  // Urgent requesters, when any are present, shut out the normal class.
  always_comb begin
    sel_oh      = u_found ? u_oh  : a_oh;
    sel_idx     = u_found ? u_idx : a_idx;
    others_wait = |(req & ~grant);
  end

  // Arbitration FSM; every release leaves one grant-free cycle for snoop settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      hold_cnt    <= '0;
      last        <= IDW'(N - 1);
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (a_found) begin
            grant       <= sel_oh;
            grant_id    <= sel_idx;
            grant_valid <= 1'b1;
            last        <= sel_idx;
            hold_cnt    <= '0;
            state       <= OWNED;
          end
        end
        OWNED: begin
          if (!req[grant_id]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if ((MAX_HOLD > 0) && (hold_cnt == HOLD_TOP) && others_wait &&
                       !lock[grant_id]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b1;
            state       <= IDLE;
          end else if (hold_cnt != HOLD_TOP) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  a_grant_onehot0: `BUS_ARB_ASSERT_ONEHOT0(clk, rst, grant);

  a_preempt_idle: assert property (@(posedge clk) disable iff (rst) preempt |-> (grant == '0));

endmodule

// File: tb/tb_bus_arbiter_qos.sv
// tb/tb_bus_arbiter_qos.sv - self-checking bench for bus_arbiter_qos

module tb_bus_arbiter_qos;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, urgent, lock;

  logic [3:0] ga, gb;
  logic [1:0] ida, idb;
  logic       va, vb, pa, pb;
  logic       gc, idc, vc, pc;

  int checks;
  int failures;
  int npre;

  always #5 clk = ~clk;

  bus_arbiter_qos #(.N(4), .MAX_HOLD(8), .FIXED_PRI(0)) dut_a (
    .clk(clk), .rst(rst), .req(req), .urgent(urgent), .lock(lock),
    .grant(ga), .grant_id(ida), .grant_valid(va), .preempt(pa)
  );

  bus_arbiter_qos #(.N(4), .MAX_HOLD(0), .FIXED_PRI(1)) dut_b (
    .clk(clk), .rst(rst), .req(req), .urgent(urgent), .lock(lock),
    .grant(gb), .grant_id(idb), .grant_valid(vb), .preempt(pb)
  );

  bus_arbiter_qos #(.N(1), .MAX_HOLD(16), .FIXED_PRI(0)) dut_c (
    .clk(clk), .rst(rst), .req(req[0]), .urgent(urgent[0]), .lock(lock[0]),
    .grant(gc), .grant_id(idc), .grant_valid(vc), .preempt(pc)
  );

  // Reference: who owns the bus (-1 = nobody), how many cycles since the grant,
  // the previous winner, and whether a forced release just happened.
  typedef struct {
    int owner;
    int held;
    int last;
    bit pre;
  } mst_t;

  mst_t m[3];

  function automatic mst_t mstep(input mst_t s, input int n, input int mh, input int fp,
                                 input logic [3:0] rq_in, input logic [3:0] ug_in,
                                 input logic [3:0] lk, input bit r);
    mst_t t;
    logic [3:0] rq;
    logic [3:0] cand;
    int w;
    t = s;
    t.pre = 1'b0;
    if (r) begin
      t.owner = -1;
      t.held  = 0;
      t.last  = n - 1;
      return t;
    end
    rq   = rq_in & 4'((1 << n) - 1);
    cand = ((rq & ug_in) != 4'b0) ? (rq & ug_in) : rq;
    if (s.owner < 0) begin
      w = -1;
      for (int k = 0; k < n; k++) begin
        int c;
        c = (fp != 0) ? k : ((s.last + 1 + k) % n);
        if (w < 0 && cand[c]) w = c;
      end
      if (w >= 0) begin
        t.owner = w;
        t.held  = 0;
        t.last  = w;
      end
    end else if (!rq[s.owner]) begin
      t.owner = -1;
    end else if (mh > 0 && s.held >= mh - 1 && (rq & ~(4'b1 << s.owner)) != 4'b0 &&
                 !lk[s.owner]) begin
      t.owner = -1;
      t.pre   = 1'b1;
    end else begin
      t.held = s.held + 1;
    end
    return t;
  endfunction

  function automatic logic [31:0] expg(input mst_t s);
    return (s.owner < 0) ? 32'd0 : (32'd1 << s.owner);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("A.grant", 32'(ga), expg(m[0]));
    chk("A.valid", 32'(va), 32'(m[0].owner >= 0));
    chk("A.preempt", 32'(pa), 32'(m[0].pre));
    if (m[0].owner >= 0) chk("A.id", 32'(ida), 32'(m[0].owner));
    chk("B.grant", 32'(gb), expg(m[1]));
    chk("B.valid", 32'(vb), 32'(m[1].owner >= 0));
    chk("B.preempt", 32'(pb), 32'(m[1].pre));
    if (m[1].owner >= 0) chk("B.id", 32'(idb), 32'(m[1].owner));
    chk("C.grant", 32'(gc), expg(m[2]));
    chk("C.valid", 32'(vc), 32'(m[2].owner >= 0));
    chk("C.preempt", 32'(pc), 32'(m[2].pre));
    if (m[2].owner >= 0) chk("C.id", 32'(idc), 32'(m[2].owner));
  endtask

  task automatic tick();
    @(posedge clk);
    m[0] = mstep(m[0], 4, 8,  0, req, urgent, lock, rst);
    m[1] = mstep(m[1], 4, 0,  1, req, urgent, lock, rst);
    m[2] = mstep(m[2], 1, 16, 0, req, urgent, lock, rst);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; urgent = 4'b0; lock = 4'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; npre = 0;
    for (int i = 0; i < 3; i++) m[i] = '{owner: -1, held: 0, last: 0, pre: 1'b0};

    // reset with unknown then all-ones requests
    rst = 1'b1; req = 4'bxxxx; urgent = 4'b0; lock = 4'b0;
    tick(); chk("rst.grant_c1", 32'(ga), 32'h0);
    req = 4'b1111;
    tick(); chk("rst.grant_c2", 32'(ga), 32'h0);
    tick(); chk("rst.grant_c3", 32'(ga), 32'h0);
    rst = 1'b0;
    tick(); chk("rst.first", 32'(ga), 32'h1); chk("rst.first_id", 32'(ida), 32'h0);

    // round-robin fairness: each grantee holds 4 cycles then drops
    for (int i = 1; i <= 4; i++) begin
      repeat (3) tick();
      req = req & ~4'(1 << ((i - 1) % 4));
      tick(); chk("rr.gap", 32'(ga), 32'h0);
      req = 4'b1111;
      tick(); chk("rr.order", 32'(ga), 32'(1 << (i % 4)));
    end

    // timeout preemption
    do_reset();
    req = 4'b0001;
    tick(); chk("to.grant0", 32'(ga), 32'h1);
    tick();
    req = 4'b0011;
    repeat (6) begin
      tick(); chk("to.hold", 32'(ga), 32'h1); chk("to.nopre", 32'(pa), 32'h0);
    end
    tick(); chk("to.preempt", 32'(pa), 32'h1); chk("to.gap", 32'(ga), 32'h0);
    tick(); chk("to.next", 32'(ga), 32'h2); chk("to.pulse", 32'(pa), 32'h0);

    // lock suppresses preemption until it falls
    do_reset();
    req = 4'b0001; lock = 4'b0001;
    tick(); tick();
    req = 4'b0011;
    repeat (18) begin
      tick(); chk("lk.held", 32'(ga), 32'h1); chk("lk.nopre", 32'(pa), 32'h0);
    end
    lock = 4'b0000;
    tick(); chk("lk.preempt", 32'(pa), 32'h1); chk("lk.gap", 32'(ga), 32'h0);
    tick(); chk("lk.next", 32'(ga), 32'h2);

    // urgent class jumps the round-robin order
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b1110; urgent = 4'b1000;
    tick(); chk("ug.gap", 32'(ga), 32'h0);
    tick(); chk("ug.grant_a", 32'(ga), 32'h8); chk("ug.id_a", 32'(ida), 32'h3);
    chk("ug.grant_b", 32'(gb), 32'h8);
    urgent = 4'b0;

    // fixed priority: requester 1 always beats 2
    do_reset();
    req = 4'b0110;
    tick(); chk("fp.first", 32'(gb), 32'h2);
    for (int r = 0; r < 3; r++) begin
      tick(); tick();
      req = 4'b0100;
      tick(); chk("fp.gap", 32'(gb), 32'h0);
      req = 4'b0110;
      tick(); chk("fp.win1", 32'(gb), 32'h2);
    end
    req = 4'b0100;
    tick(); chk("fp.gap2", 32'(gb), 32'h0);
    tick(); chk("fp.win2", 32'(gb), 32'h4);

    // unlimited hold never preempts
    req = 4'b0111;
    repeat (1000) begin
      tick();
      if (pb) npre++;
    end
    chk("mh0.grant", 32'(gb), 32'h4);
    chk("mh0.preempts", 32'(npre), 32'h0);

    // randomized traffic against the reference
    do_reset();
    repeat (2000) begin
      req    = req ^ 4'($urandom & $urandom & $urandom);
      urgent = 4'($urandom & $urandom);
      lock   = 4'($urandom);
      rst    = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
